pipe_fetch: RTL

//  Instruction fetch stage of the hxd32 pipeline; sits directly upstream of the IF/ID pipe register.

---
 rtl/pipe_fetch_if.sv | 34 +++
 rtl/pipe_fetch.sv | 113 +++++++++++
 2 files changed

// File: rtl/pipe_fetch_if.sv
// Bundle of the instruction-memory request port and the fetch output port of pipe_fetch.
// master = fetch stage, slave = memory + IF/ID register side.
interface pipe_fetch_if #(
  parameter int XLEN = 32
) ();
  // imem_req_o/imem_gnt_i and inst_valid_o/inst_ready_i are valid/ready pairs: a transfer
  // happens on a rising edge where both are high, and the source holds valid and payload
  // stable until then. A redirect is the one exception: it may withdraw inst_valid_o.
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [XLEN-1:0] pc_data_o;
  logic [XLEN-1:0] pc_next_o;
  logic [31:0]     inst_data_o;
  logic            inst_fault_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output inst_valid_o, pc_data_o, pc_next_o, inst_data_o, inst_fault_o,
    input  inst_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  inst_valid_o, pc_data_o, pc_next_o, inst_data_o, inst_fault_o,
    output inst_ready_i
  );
endinterface

// File: rtl/pipe_fetch.sv
// hxd32 instruction fetch stage: in-order imem requests, response FIFO, redirect flush.
// Optional misaligned-redirect fault handling is enabled by defining HXD32_FETCH_ALIGN_CHK_EN.
module pipe_fetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  pipe_fetch_if.master    bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic            started;
  logic [XLEN-1:0] fetch_pc, resp_pc, redir_pc;
  logic [CW-1:0]   inflight, drop_cnt, fifo_cnt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [XLEN-1:0] mem_pc   [FIFO_DEPTH];
  logic [31:0]     mem_inst [FIFO_DEPTH];
  logic            credit, req, grant, rsp, rsp_push, fault_push, push, pop, halted;

`ifdef HXD32_FETCH_ALIGN_CHK_EN
  logic                  fault_pend;
  logic [FIFO_DEPTH-1:0] mem_fault;

  assign redir_pc   = redirect_pc_i;
  // The fault entry waits until every stale response is gone, so it is the only thing queued.
  assign fault_push = fault_pend && (drop_cnt == '0) && !redirect_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      halted     <= 1'b0;
      fault_pend <= 1'b0;
      mem_fault  <= '0;
    end else begin
      if (redirect_i) begin
        halted     <= (redir_pc[1:0] != 2'b00);
        fault_pend <= (redir_pc[1:0] != 2'b00);
      end else if (fault_push) begin
        fault_pend <= 1'b0;
      end
      if (push && !redirect_i) mem_fault[wr_ptr] <= fault_push;
    end
  end

  assign bus.inst_fault_o = mem_fault[rd_ptr];
`else
  assign redir_pc         = redirect_pc_i & ~XLEN'(3);
  assign fault_push       = 1'b0;
  assign halted           = 1'b0;
  assign bus.inst_fault_o = 1'b0;
`endif

  // Stale responses still count in inflight, so the credit also reserves room for them.
  assign credit   = ({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_W;
  assign req      = started && !redirect_i && credit && !halted;
  assign grant    = req && bus.imem_gnt_i;
  assign rsp      = bus.imem_rvalid_i && (inflight != '0);
  assign rsp_push = rsp && !redirect_i && (drop_cnt == '0);
  assign push     = rsp_push || fault_push;
  assign pop      = bus.inst_valid_o && bus.inst_ready_i && !redirect_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      started  <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else begin
      // Keeps the request low during and right after reset.
      started  <= 1'b1;
      inflight <= inflight + CW'(grant) - CW'(rsp);
      if (redirect_i) begin
        fetch_pc <= redir_pc;
        resp_pc  <= redir_pc;
        drop_cnt <= inflight - CW'(rsp);
        fifo_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (rsp_push) resp_pc <= resp_pc + XLEN'(4);
        if (push) begin
          mem_pc[wr_ptr]   <= resp_pc;
          mem_inst[wr_ptr] <= fault_push ? 32'h0000_0013 : bus.imem_rdata_i;
          wr_ptr           <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = fetch_pc;
  assign bus.inst_valid_o = (fifo_cnt != '0);
  assign bus.pc_data_o    = mem_pc[rd_ptr];
  assign bus.pc_next_o    = mem_pc[rd_ptr] + XLEN'(4);
  assign bus.inst_data_o  = mem_inst[rd_ptr];
endmodule
